// File: rtl/mem_dev_router.sv
// Memory-stage request router: accepts one LSU request at a time and steers it
// to the CLINT port or the external bridge port. Misaligned requests fault locally.
module mem_dev_router #(
    parameter int unsigned          DATA_W     = 64,
    parameter int unsigned          ADDR_W     = 64,
    parameter logic [ADDR_W-1:0]    CLINT_BASE = 64'h0000_0000_0200_0000,
    parameter logic [ADDR_W-1:0]    CLINT_MASK = 64'hFFFF_FFFF_FFFF_0000
) (
    input  logic              clk,
    input  logic              rst,

    // Handshakes: a request transfers on a rising edge where valid & ready are both 1.
    // LSU side: lsu_ready_o is high only in IDLE. Device side: the router holds
    // *_valid_o and the latched fields stable until the device returns *_ready_i = 1.
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [1:0]        lsu_size_i,
    input  logic [DATA_W-1:0] lsu_data_write_i,
    output logic              lsu_resp_valid_o,
    output logic [DATA_W-1:0] lsu_data_read_o,
    output logic [1:0]        lsu_resp_o,

    output logic              clint_valid_o,
    output logic              clint_req_o,
    output logic [ADDR_W-1:0] clint_addr_o,
    output logic [1:0]        clint_size_o,
    output logic [DATA_W-1:0] clint_data_write_o,
    input  logic              clint_ready_i,
    input  logic [DATA_W-1:0] clint_data_read_i,
    input  logic [1:0]        clint_resp_i,

    output logic              ext_valid_o,
    output logic              ext_req_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic [1:0]        ext_size_o,
    output logic [DATA_W-1:0] ext_data_write_o,
    input  logic              ext_ready_i,
    input  logic [DATA_W-1:0] ext_data_read_i,
    input  logic [1:0]        ext_resp_i,

    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLINT = 2'd1,
        S_EXT   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;

    logic misaligned;
    logic is_clint;
    logic accept;
    logic clint_done;
    logic ext_done;

    always_comb begin
        misaligned = 1'b0;
        case (lsu_size_i)
            2'd1:    misaligned = lsu_addr_i[0];
            2'd2:    misaligned = |lsu_addr_i[1:0];
            2'd3:    misaligned = |lsu_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign is_clint   = (lsu_addr_i & CLINT_MASK) == CLINT_BASE;
    assign accept     = (state_q == S_IDLE)  && lsu_valid_i;
    assign clint_done = (state_q == S_CLINT) && clint_ready_i;
    assign ext_done   = (state_q == S_EXT)   && ext_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_valid_i) begin
                    if (misaligned)    state_d = S_RESP;
                    else if (is_clint) state_d = S_CLINT;
                    else               state_d = S_EXT;
                end
            end
            S_CLINT: if (clint_ready_i) state_d = S_RESP;
            S_EXT:   if (ext_ready_i)   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch plus response registers; the response holds until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            if (accept) begin
                req_q   <= lsu_req_i;
                addr_q  <= lsu_addr_i;
                size_q  <= lsu_size_i;
                wdata_q <= lsu_data_write_i;
                if (misaligned) begin
                    rdata_q <= '0;
                    resp_q  <= 2'b10;
                end
            end
            if (clint_done) begin
                rdata_q <= req_q ? '0 : clint_data_read_i;
                resp_q  <= clint_resp_i;
            end
            if (ext_done) begin
                rdata_q <= req_q ? '0 : ext_data_read_i;
                resp_q  <= ext_resp_i;
            end
        end
    end

    always_comb begin
        clint_valid_o      = 1'b0;
        clint_req_o        = 1'b0;
        clint_addr_o       = '0;
        clint_size_o       = '0;
        clint_data_write_o = '0;
        ext_valid_o        = 1'b0;
        ext_req_o          = 1'b0;
        ext_addr_o         = '0;
        ext_size_o         = '0;
        ext_data_write_o   = '0;
        if (state_q == S_CLINT) begin
            clint_valid_o      = 1'b1;
            clint_req_o        = req_q;
            clint_addr_o       = addr_q;
            clint_size_o       = size_q;
            clint_data_write_o = wdata_q;
        end
        if (state_q == S_EXT) begin
            ext_valid_o      = 1'b1;
            ext_req_o        = req_q;
            ext_addr_o       = addr_q;
            ext_size_o       = size_q;
            ext_data_write_o = wdata_q;
        end
    end

    assign lsu_ready_o      = (state_q == S_IDLE);
    assign lsu_resp_valid_o = (state_q == S_RESP);
    assign lsu_data_read_o  = rdata_q;
    assign lsu_resp_o       = resp_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_dev_router.sv
// Table-driven bench for mem_dev_router: directed vectors with hand-computed
// routing, data, response and latency, plus reset corner sequences.
module tb_mem_dev_router;

    localparam logic [1:0] R_CLINT = 2'd0;
    localparam logic [1:0] R_EXT   = 2'd1;
    localparam logic [1:0] R_FAULT = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic        lsu_req_i;
    logic [63:0] lsu_addr_i;
    logic [1:0]  lsu_size_i;
    logic [63:0] lsu_data_write_i;
    logic        lsu_resp_valid_o;
    logic [63:0] lsu_data_read_o;
    logic [1:0]  lsu_resp_o;
    logic        clint_valid_o;
    logic        clint_req_o;
    logic [63:0] clint_addr_o;
    logic [1:0]  clint_size_o;
    logic [63:0] clint_data_write_o;
    logic        clint_ready_i;
    logic [63:0] clint_data_read_i;
    logic [1:0]  clint_resp_i;
    logic        ext_valid_o;
    logic        ext_req_o;
    logic [63:0] ext_addr_o;
    logic [1:0]  ext_size_o;
    logic [63:0] ext_data_write_o;
    logic        ext_ready_i;
    logic [63:0] ext_data_read_i;
    logic [1:0]  ext_resp_i;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_dev_router dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_ready_o        (lsu_ready_o),
        .lsu_req_i          (lsu_req_i),
        .lsu_addr_i         (lsu_addr_i),
        .lsu_size_i         (lsu_size_i),
        .lsu_data_write_i   (lsu_data_write_i),
        .lsu_resp_valid_o   (lsu_resp_valid_o),
        .lsu_data_read_o    (lsu_data_read_o),
        .lsu_resp_o         (lsu_resp_o),
        .clint_valid_o      (clint_valid_o),
        .clint_req_o        (clint_req_o),
        .clint_addr_o       (clint_addr_o),
        .clint_size_o       (clint_size_o),
        .clint_data_write_o (clint_data_write_o),
        .clint_ready_i      (clint_ready_i),
        .clint_data_read_i  (clint_data_read_i),
        .clint_resp_i       (clint_resp_i),
        .ext_valid_o        (ext_valid_o),
        .ext_req_o          (ext_req_o),
        .ext_addr_o         (ext_addr_o),
        .ext_size_o         (ext_size_o),
        .ext_data_write_o   (ext_data_write_o),
        .ext_ready_i        (ext_ready_i),
        .ext_data_read_i    (ext_data_read_i),
        .ext_resp_i         (ext_resp_i),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic        req;
        logic [63:0] wdata;
        logic [63:0] dev_data;
        logic [1:0]  dev_resp;
        int          delay;     // ext_ready_i asserted this many cycles after ext_valid_o rises
        bit          hold;      // keep lsu_valid_i high with scrambled fields while busy
        logic [1:0]  route;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        lsu_valid_i       = 1'b0;
        lsu_req_i         = 1'b0;
        lsu_addr_i        = '0;
        lsu_size_i        = '0;
        lsu_data_write_i  = '0;
        clint_ready_i     = 1'b0;
        clint_data_read_i = '0;
        clint_resp_i      = '0;
        ext_ready_i       = 1'b0;
        ext_data_read_i   = '0;
        ext_resp_i        = '0;
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after a posedge, idle again.
    task automatic run_vec(input int idx, input vec_t v);
        int   cyc, ext_seen, resp_cyc, exp_lat;
        bit   saw_clint, saw_ext, fields_ok, busy_ok;
        logic [1:0] got_route;
        string tag;
        tag = $sformatf("v%0d", idx);
        cyc = 0; ext_seen = 0; resp_cyc = 0;
        saw_clint = 0; saw_ext = 0; fields_ok = 1; busy_ok = 1;
        lsu_valid_i       = 1'b1;
        lsu_req_i         = v.req;
        lsu_addr_i        = v.addr;
        lsu_size_i        = v.size;
        lsu_data_write_i  = v.wdata;
        clint_ready_i     = 1'b1;
        clint_data_read_i = v.dev_data;
        clint_resp_i      = v.dev_resp;
        ext_data_read_i   = v.dev_data;
        ext_resp_i        = v.dev_resp;
        ext_ready_i       = (v.route == R_CLINT);
        check({tag, "_accept_ready"}, lsu_ready_o, 1'b1);
        while (resp_cyc == 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (v.hold) begin
                lsu_addr_i       = 64'h0000_0000_8000_0000;
                lsu_data_write_i = '1;
                lsu_req_i        = ~v.req;
                lsu_size_i       = ~v.size;
            end else begin
                lsu_valid_i = 1'b0;
            end
            if (v.route != R_CLINT) ext_ready_i = 1'b0;
            if (lsu_ready_o) busy_ok = 0;
            if (clint_valid_o) begin
                saw_clint = 1;
                if (clint_addr_o !== v.addr || clint_size_o !== v.size ||
                    clint_req_o !== v.req || clint_data_write_o !== v.wdata) fields_ok = 0;
            end
            if (ext_valid_o) begin
                saw_ext = 1;
                if (ext_addr_o !== v.addr || ext_size_o !== v.size ||
                    ext_req_o !== v.req || ext_data_write_o !== v.wdata) fields_ok = 0;
                if (ext_seen == v.delay) ext_ready_i = 1'b1;
                ext_seen++;
            end
            if (lsu_resp_valid_o) begin
                resp_cyc = cyc;
                lsu_valid_i = 1'b0;
                check({tag, "_rdata"}, lsu_data_read_o, v.exp_data);
                check({tag, "_resp"}, lsu_resp_o, v.exp_resp);
            end
        end
        ext_ready_i   = 1'b0;
        clint_ready_i = 1'b0;
        if (saw_clint && !saw_ext)       got_route = R_CLINT;
        else if (saw_ext && !saw_clint)  got_route = R_EXT;
        else if (!saw_ext && !saw_clint) got_route = R_FAULT;
        else                             got_route = 2'd3;
        exp_lat = (v.route == R_FAULT) ? 1 : (v.route == R_CLINT) ? 2 : v.delay + 2;
        check({tag, "_route"}, got_route, v.route);
        check({tag, "_latency"}, resp_cyc, exp_lat);
        check({tag, "_fields_stable"}, fields_ok, 1'b1);
        check({tag, "_ready_low_busy"}, busy_ok, 1'b1);
        @(posedge clk); #1;
        check({tag, "_resp_one_cycle"}, lsu_resp_valid_o, 1'b0);
        check({tag, "_ready_after"}, lsu_ready_o, 1'b1);
        check({tag, "_resp_holds"}, lsu_resp_o, v.exp_resp);
        check({tag, "_no_dev_valid_after"}, {clint_valid_o, ext_valid_o}, 2'b00);
    endtask

    initial begin
        //                 addr                     size  req wdata        dev_data      dres  dly hold route    exp_data      exp_resp
        vecs[0]  = '{64'h0000_0000_0200_4000, 2'd3, 1'b1, 64'h1234, 64'h5555,      2'b00, 0, 0, R_CLINT, 64'h0,         2'b00};
        vecs[1]  = '{64'h0000_0000_0200_BFF8, 2'd3, 1'b0, 64'h0,    64'hABCD,      2'b00, 0, 0, R_CLINT, 64'hABCD,      2'b00};
        vecs[2]  = '{64'h0000_0000_8000_0000, 2'd3, 1'b0, 64'h0,    64'hDEAD_BEEF, 2'b00, 5, 0, R_EXT,   64'hDEAD_BEEF, 2'b00};
        vecs[3]  = '{64'h0000_0000_8000_0002, 2'd2, 1'b0, 64'h0,    64'h9999,      2'b00, 0, 0, R_FAULT, 64'h0,         2'b10};
        vecs[4]  = '{64'h0000_0000_0201_0000, 2'd3, 1'b0, 64'h0,    64'h77,        2'b00, 0, 0, R_EXT,   64'h77,        2'b00};
        vecs[5]  = '{64'h0000_0000_01FF_FFFF, 2'd0, 1'b0, 64'h0,    64'h11,        2'b00, 1, 0, R_EXT,   64'h11,        2'b00};
        vecs[6]  = '{64'h0000_0000_0200_FFF8, 2'd3, 1'b0, 64'h0,    64'h22,        2'b00, 0, 1, R_CLINT, 64'h22,        2'b00};
        vecs[7]  = '{64'h0000_0000_0200_FFFF, 2'd0, 1'b0, 64'h0,    64'h33,        2'b11, 0, 0, R_CLINT, 64'h33,        2'b11};
        vecs[8]  = '{64'h0000_0000_0000_1001, 2'd1, 1'b1, 64'hCAFE, 64'h44,        2'b00, 0, 0, R_FAULT, 64'h0,         2'b10};
        vecs[9]  = '{64'h0000_0000_9000_0008, 2'd2, 1'b1, 64'hBEEF, 64'hFFFF,      2'b01, 2, 1, R_EXT,   64'h0,         2'b01};
        vecs[10] = '{64'h0000_0000_8000_0006, 2'd1, 1'b0, 64'h0,    64'h0123_4567, 2'b00, 0, 0, R_EXT,   64'h0123_4567, 2'b00};

        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", lsu_ready_o, 1'b1);
        check("rst_resp_valid", lsu_resp_valid_o, 1'b0);
        check("rst_rdata", lsu_data_read_o, 64'h0);
        check("rst_resp", lsu_resp_o, 2'b00);
        check("rst_dev_valid", {clint_valid_o, ext_valid_o}, 2'b00);
        check("rst_dev_fields", {clint_addr_o, ext_addr_o} != '0, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while an external access is pending: drop it with no response.
        lsu_valid_i = 1'b1;
        lsu_req_i   = 1'b0;
        lsu_addr_i  = 64'h0000_0000_8000_0000;
        lsu_size_i  = 2'd3;
        @(posedge clk); #1;
        lsu_valid_i = 1'b0;
        check("mid_ext_valid", ext_valid_o, 1'b1);
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_async_drop", ext_valid_o, 1'b0);
        check("mid_rst_ready", lsu_ready_o, 1'b1);
        check("mid_rst_resp_cleared", lsu_resp_o, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        ext_ready_i = 1'b1;
        begin
            bit stale;
            stale = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                if (lsu_resp_valid_o || ext_valid_o || !lsu_ready_o) stale = 1;
            end
            check("post_rst_no_stale", stale, 1'b0);
        end
        ext_ready_i = 1'b0;
        run_vec(11, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
